linear_network_gather_seq: RTL and testbench
============================================

// Module: linear_network_gather_seq
// PURPOSE
//  Collection (many-to-one) counterpart of the unicast linear chain: NUM_NODE nodes each inject
//  packets into a registered chain that drains toward node 0 and out a single output port.
//  Each packet carries its source tag (node index) so the consumer knows its origin.
//  Used to gather PE results back to a buffer; one register stage per node, bounded-wait fairness.
// PARAMETERS
//  DATA_WIDTH     32  payload width per packet
//  NUM_NODE       4   nodes in the chain (>=2); node NUM_NODE-1 is farthest from the output
//  COMMAND_WIDTH  $clog2(NUM_NODE)  source-tag width
//  STARVE_LIMIT   4   max cycles a valid local request is refused before it overrides transit (>=1)
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    reset, asynchronous, active-high
//  i_en         in   1                    chain enable; 0 = whole chain stalls/holds
//  i_valid      in   NUM_NODE             per-node injection request
//  i_data_bus   in   NUM_NODE*DATA_WIDTH  per-node payload, node k at [k*DATA_WIDTH+:DATA_WIDTH]
//  o_ready      out  NUM_NODE             per-node accept; transfer when i_valid[k]&o_ready[k] at edge
//  o_valid      out  1                    gathered packet valid
//  o_data_bus   out  DATA_WIDTH           gathered payload
//  o_src        out  COMMAND_WIDTH        source node index of gathered packet
// BEHAVIOUR
//  - Clock clk, one clock domain; rst asynchronous active-high. While rst=1: all stage regs empty,
//    wait counters 0, o_valid=0, o_data_bus=0, o_src=0, o_ready=0.
//  - State per node k: R_k = {v, data, src} and wait_k (saturating, 0..STARVE_LIMIT).
//  - up_v_k = R_{k+1}.v (k<NUM_NODE-1), else 0. drain_0 = i_en; drain_k = take_up_{k-1}.
//  - free_k = i_en & (~R_k.v | drain_k). urgent_k = (wait_k == STARVE_LIMIT).
//  - take_up_k = free_k & up_v_k & ~(i_valid[k] & urgent_k).
//  - o_ready[k] = free_k & ~take_up_k... defined as free_k & (~up_v_k | urgent_k); must not depend
//    on i_valid[k] (may depend on other nodes' i_valid via the drain chain; combinational, N deep).
//  - Edge update: take_up_k -> R_k <= R_{k+1}; else i_valid[k]&o_ready[k] -> R_k <= {1,data_k,k};
//    else free_k -> R_k.v <= 0; else hold. Upstream packet not taken stays in R_{k+1} (no loss).
//  - wait_k: i_en & i_valid[k] & ~o_ready[k] -> +1 saturating; accept or ~i_valid[k] -> 0;
//    i_en=0 -> hold.
//  - Outputs: o_valid = R_0.v & i_en; o_data_bus/o_src = R_0 fields when o_valid, else 0.
//  - Latency: packet accepted at node k on edge E is on the output during the cycle after edge
//    E+k when no override occurs (node 0: cycle after accept edge).
//  - Ordering: packets from the same node leave in injection order; priority is transit-first,
//    local wins only when urgent; any request waits at most STARVE_LIMIT+1 enabled cycles
//    once the chain ahead of it moves.
//  - i_en=0: all regs and counters hold, o_ready=0, o_valid=0; on re-enable flow resumes with no
//    loss or duplication. i_valid while i_en=0 is ignored.
//  - rst mid-operation: all in-flight packets discarded, no partial output.
// TESTING
//  1 Reset: rst=1 for 2 cycles with i_valid=4'hF -> o_valid=0, o_ready=0, o_data_bus=0, o_src=0.
//  2 Single: i_en=1, node3 pulses 32'hAAAAAAAA -> o_ready[3]=1 same cycle, o_valid=1 one cycle,
//    4 cycles after accept, o_src=3, o_data_bus=32'hAAAAAAAA; no other o_valid.
//  3 Simultaneous: node0=32'h0000000B and node3=32'hAAAAAAAA same cycle -> both accepted; node0
//    out next cycle (o_src=0), node3 out 3 cycles later (o_src=3).
//  4 Starvation: node3 streams continuously, node1 holds 32'hBBBBBBBB valid -> o_ready[1]=0 for
//    4 cycles after chain fills, then accepted; o_ready[3] drops exactly 1 cycle; no node3 loss.
//  5 Stall: i_en=0 for 3 cycles with 3 packets in flight -> o_valid=0, o_ready=0; after re-enable
//    the 3 packets emerge in original order, each once.
//  6 Mid-op reset: rst pulse with chain full -> o_valid=0 next cycle and no stale packet after
//    release; wait counters 0 (node refused immediately re-counts from 0).

Source files
------------

// File: rtl/linear_network_gather_seq.sv
// Many-to-one gather chain: each node injects tagged packets into a registered chain draining
// toward node 0. Transit traffic has priority; a local request refused STARVE_LIMIT times wins.
module linear_network_gather_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_NODE      = 4,
  parameter int COMMAND_WIDTH = $clog2(NUM_NODE),
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic [NUM_NODE-1:0]            i_valid,
  input  logic [NUM_NODE*DATA_WIDTH-1:0] i_data_bus,
  output logic [NUM_NODE-1:0]            o_ready,
  output logic                           o_valid,
  output logic [DATA_WIDTH-1:0]          o_data_bus,
  output logic [COMMAND_WIDTH-1:0]       o_src
);

  localparam int WAIT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = WAIT_WIDTH'(STARVE_LIMIT);
  localparam logic [WAIT_WIDTH-1:0] WAIT_ONE = WAIT_WIDTH'(1);

  logic [NUM_NODE-1:0]      r_v;
  logic [DATA_WIDTH-1:0]    r_data [NUM_NODE];
  logic [COMMAND_WIDTH-1:0] r_src  [NUM_NODE];
  logic [WAIT_WIDTH-1:0]    r_wait [NUM_NODE];

  logic                     w_en;
  logic [NUM_NODE-1:0]      w_up_v;
  logic [NUM_NODE-1:0]      w_free;
  logic [NUM_NODE-1:0]      w_take_up;
  logic [NUM_NODE-1:0]      w_ready;
  logic [NUM_NODE-1:0]      w_accept;
  logic [DATA_WIDTH-1:0]    w_up_data [NUM_NODE];
  logic [COMMAND_WIDTH-1:0] w_up_src  [NUM_NODE];

  // Reset also blocks any handshake so o_ready reads 0 while rst is high.
  assign w_en     = i_en & ~rst;
  assign w_up_v   = {1'b0, r_v[NUM_NODE-1:1]};
  assign w_accept = i_valid & w_ready;

  for (genvar k = 0; k < NUM_NODE; k++) begin : g_up
    if (k < NUM_NODE - 1) begin : g_mid
      assign w_up_data[k] = r_data[k+1];
      assign w_up_src[k]  = r_src[k+1];
    end else begin : g_far
      assign w_up_data[k] = '0;
      assign w_up_src[k]  = '0;
    end
  end

  // Vacancy ripples upward from the output: node k drains only if node k-1 pulls from it.
  always_comb begin
    logic drain;
    logic free;
    logic urgent;
    logic take;
    w_free    = '0;
    w_take_up = '0;
    w_ready   = '0;
    drain     = w_en;
    for (int k = 0; k < NUM_NODE; k++) begin
      urgent       = (r_wait[k] == WAIT_MAX);
      free         = w_en & (~r_v[k] | drain);
      take         = free & w_up_v[k] & ~(i_valid[k] & urgent);
      w_free[k]    = free;
      w_take_up[k] = take;
      w_ready[k]   = free & (~w_up_v[k] | urgent);
      drain        = take;
    end
  end

  // Stage registers and per-node starvation counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < NUM_NODE; k++) begin
        r_data[k] <= '0;
        r_src[k]  <= '0;
        r_wait[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_NODE; k++) begin
        if (w_take_up[k]) begin
          r_v[k]    <= 1'b1;
          r_data[k] <= w_up_data[k];
          r_src[k]  <= w_up_src[k];
        end else if (w_accept[k]) begin
          r_v[k]    <= 1'b1;
          r_data[k] <= i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
          r_src[k]  <= COMMAND_WIDTH'(k);
        end else if (w_free[k]) begin
          r_v[k]    <= 1'b0;
        end
        if (w_en) begin
          if (i_valid[k] & ~w_ready[k]) begin
            if (r_wait[k] != WAIT_MAX) begin
              r_wait[k] <= r_wait[k] + WAIT_ONE;
            end
          end else begin
            r_wait[k] <= '0;
          end
        end
      end
    end
  end

  assign o_ready    = w_ready;
  assign o_valid    = r_v[0] & w_en;
  assign o_data_bus = o_valid ? r_data[0] : '0;
  assign o_src      = o_valid ? r_src[0] : '0;

endmodule

// File: tb/tb_linear_network_gather_seq.sv
// Self-checking bench for linear_network_gather_seq: directed vector table, corner-case
// sequences, and randomized traffic against a slot-level reference model plus a scoreboard.
module tb_linear_network_gather_seq;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LIMIT = 4;
  localparam logic [127:0] BUS_AB = {32'hAAAAAAAA, 32'h00000000, 32'h00000000, 32'h0000000B};

  logic           clk = 1'b0;
  logic           rst;
  logic           i_en;
  logic [N-1:0]   i_valid;
  logic [N*DW-1:0] i_data_bus;
  logic [N-1:0]   o_ready;
  logic           o_valid;
  logic [DW-1:0]  o_data_bus;
  logic [1:0]     o_src;

  linear_network_gather_seq #(.DATA_WIDTH(DW), .NUM_NODE(N), .COMMAND_WIDTH(2), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .o_ready(o_ready), .o_valid(o_valid), .o_data_bus(o_data_bus), .o_src(o_src)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] v;
    logic [3:0] rdy;
    logic       ov;
    logic [1:0] s;
    logic [31:0] d;
  } vec_t;

  typedef struct packed {
    logic [1:0]  s;
    logic [31:0] d;
  } ent_t;

  vec_t tbl[16];
  ent_t sbq[$];
  logic [31:0] outs[$];

  // Producer state: a node holds its packet until the handshake completes.
  bit          pend[N];
  logic [31:0] pdat[N];
  logic [3:0]  smp_ready;
  logic        smp_ov;
  logic [31:0] smp_d;
  logic [1:0]  smp_s;

  // Reference model: one slot per node, slot N is a permanently empty sentinel.
  int          m_v[N+1];
  logic [31:0] m_d[N+1];
  int          m_s[N+1];
  int          m_w[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(logic r, logic e, logic [3:0] v, logic [3:0] rd, logic ov,
                              logic [1:0] s, logic [31:0] d);
    vec_t t;
    t.r = r; t.e = e; t.v = v; t.rdy = rd; t.ov = ov; t.s = s; t.d = d;
    return t;
  endfunction

  task automatic model_cycle(input logic r, input logic e, input logic [3:0] v,
                             input logic [127:0] bus, output logic [3:0] rdy, output logic ov,
                             output logic [31:0] od, output logic [1:0] os);
    int nv[N+1];
    logic [31:0] nd[N+1];
    int ns[N+1];
    bit leaving, room, above, urgent, pull;
    rdy = '0; ov = 1'b0; od = '0; os = '0;
    if (r) begin
      for (int k = 0; k <= N; k++) begin m_v[k] = 0; m_d[k] = '0; m_s[k] = 0; end
      for (int k = 0; k < N; k++) m_w[k] = 0;
    end else if (e) begin
      if (m_v[0] != 0) begin ov = 1'b1; od = m_d[0]; os = 2'(m_s[0]); end
      for (int k = 0; k <= N; k++) begin nv[k] = m_v[k]; nd[k] = m_d[k]; ns[k] = m_s[k]; end
      leaving = 1'b1;
      for (int k = 0; k < N; k++) begin
        room   = (m_v[k] == 0) || leaving;
        above  = (m_v[k+1] != 0);
        urgent = (m_w[k] == LIMIT);
        rdy[k] = room && (!above || urgent);
        pull   = room && above && !(v[k] && urgent);
        if (pull) begin
          nv[k] = 1; nd[k] = m_d[k+1]; ns[k] = m_s[k+1];
        end else if (v[k] && rdy[k]) begin
          nv[k] = 1; nd[k] = bus[k*32 +: 32]; ns[k] = k;
        end else if (room) begin
          nv[k] = 0;
        end
        if (v[k] && !rdy[k]) m_w[k] = (m_w[k] < LIMIT) ? m_w[k] + 1 : LIMIT;
        else m_w[k] = 0;
        leaving = pull;
      end
      for (int k = 0; k < N; k++) begin m_v[k] = nv[k]; m_d[k] = nd[k]; m_s[k] = ns[k]; end
    end
  endtask

  task automatic sb_pop(input logic [1:0] s, input logic [31:0] d);
    int idx;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++) if (idx < 0 && sbq[i].s == s) idx = i;
    n_total++;
    if (idx < 0) begin
      $display("FAIL sb_unexpected: got src %0d data %0h expected no packet", s, d);
    end else begin
      if (sbq[idx].d === d) n_pass++;
      else $display("FAIL sb_order src%0d: got %0h expected %0h", s, d, sbq[idx].d);
      sbq.delete(idx);
    end
  endtask

  task automatic step(input logic r, input logic e);
    logic [3:0] vv;
    logic [127:0] bb;
    logic [3:0] er;
    logic eov;
    logic [31:0] ed;
    logic [1:0] es;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin vv[k] = pend[k]; bb[k*32 +: 32] = pdat[k]; end
    rst = r; i_en = e; i_valid = vv; i_data_bus = bb;
    #1;
    smp_ready = o_ready; smp_ov = o_valid; smp_d = o_data_bus; smp_s = o_src;
    model_cycle(r, e, vv, bb, er, eov, ed, es);
    chk("m_ready", smp_ready, er);
    chk("m_valid", smp_ov, eov);
    chk("m_data", smp_d, ed);
    chk("m_src", smp_s, es);
    if (smp_ov) sb_pop(smp_s, smp_d);
    if (!r && e) begin
      for (int k = 0; k < N; k++) begin
        if (pend[k] && smp_ready[k]) begin
          sbq.push_back({2'(k), pdat[k]});
          pend[k] = 1'b0;
        end
      end
    end
    if (r) sbq.delete();
  endtask

  task automatic clear_pend();
    for (int k = 0; k < N; k++) begin pend[k] = 1'b0; pdat[k] = '0; end
  endtask

  // Node 3 streams, node 1 raises a request once the chain ahead of it is full.
  task automatic run_starve(input bit do_reset, input string tag);
    int ref1, low3;
    bit b1, b3;
    logic [31:0] seq;
    clear_pend();
    if (do_reset) step(1'b1, 1'b1);
    seq = 32'h30000000;
    ref1 = 0; low3 = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 16 && !pend[3]) begin pend[3] = 1'b1; pdat[3] = seq; seq++; end
      if (c == 4) begin pend[1] = 1'b1; pdat[1] = 32'hBBBBBBBB; end
      b1 = pend[1]; b3 = pend[3];
      step(1'b0, 1'b1);
      if (b1 && !smp_ready[1]) ref1++;
      if (b3 && !smp_ready[3]) low3++;
    end
    chk({tag, "_n1_refused"}, ref1, LIMIT);
    chk({tag, "_n3_stall"}, low3, 1);
    chk({tag, "_n1_accepted"}, pend[1], 1'b0);
    pend[3] = 1'b0;
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
    chk({tag, "_drained"}, sbq.size(), 0);
  endtask

  initial begin
    int nov;
    bit r, e;
    rst = 1'b1; i_en = 1'b0; i_valid = '0; i_data_bus = '0;
    clear_pend();
    tbl[0]  = mk(1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 32'h0);
    tbl[1]  = mk(1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 2'd0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 32'h0);
    tbl[3]  = mk(1'b0, 1'b1, 4'h8, 4'hF, 1'b0, 2'd0, 32'h0);
    tbl[4]  = mk(1'b0, 1'b1, 4'h0, 4'hB, 1'b0, 2'd0, 32'h0);
    tbl[5]  = mk(1'b0, 1'b1, 4'h0, 4'hD, 1'b0, 2'd0, 32'h0);
    tbl[6]  = mk(1'b0, 1'b1, 4'h0, 4'hE, 1'b0, 2'd0, 32'h0);
    tbl[7]  = mk(1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 2'd3, 32'hAAAAAAAA);
    tbl[8]  = mk(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 32'h0);
    tbl[9]  = mk(1'b0, 1'b1, 4'h9, 4'hF, 1'b0, 2'd0, 32'h0);
    tbl[10] = mk(1'b0, 1'b1, 4'h0, 4'hB, 1'b1, 2'd0, 32'h0000000B);
    tbl[11] = mk(1'b0, 1'b1, 4'h0, 4'hD, 1'b0, 2'd0, 32'h0);
    tbl[12] = mk(1'b0, 1'b1, 4'h0, 4'hE, 1'b0, 2'd0, 32'h0);
    tbl[13] = mk(1'b0, 1'b1, 4'h0, 4'hF, 1'b1, 2'd3, 32'hAAAAAAAA);
    tbl[14] = mk(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, 32'h0);
    tbl[15] = mk(1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst = tbl[i].r; i_en = tbl[i].e; i_valid = tbl[i].v; i_data_bus = BUS_AB;
      #1;
      chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_src", i), o_src, tbl[i].s);
      chk($sformatf("tbl%0d_data", i), o_data_bus, tbl[i].d);
    end

    run_starve(1'b1, "starve");

    // Stall with three node-3 packets in flight.
    clear_pend();
    step(1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      pend[3] = 1'b1; pdat[3] = 32'h51 + 32'(c);
      step(1'b0, 1'b1);
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0);
      chk("stall_valid", smp_ov, 1'b0);
      chk("stall_ready", smp_ready, 4'h0);
    end
    outs.delete();
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1);
      if (smp_ov) outs.push_back(smp_d);
    end
    chk("stall_count", outs.size(), 3);
    if (outs.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("stall_order%0d", i), outs[i], 32'h51 + 32'(i));
    end

    // Reset while the chain is full and node 1 is being refused.
    clear_pend();
    step(1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (!pend[3]) begin pend[3] = 1'b1; pdat[3] = 32'h70 + 32'(c); end
      if (c == 3) begin pend[1] = 1'b1; pdat[1] = 32'hCCCCCCCC; end
      step(1'b0, 1'b1);
    end
    step(1'b1, 1'b1);
    chk("rst_mid_valid", smp_ov, 1'b0);
    chk("rst_mid_ready", smp_ready, 4'h0);
    clear_pend();
    nov = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1);
      if (smp_ov) nov++;
    end
    chk("rst_no_stale", nov, 0);
    run_starve(1'b0, "rst_restarve");

    // Randomized traffic with occasional stalls and resets.
    clear_pend();
    step(1'b1, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 399) == 0);
      e = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin pend[k] = 1'b1; pdat[k] = $urandom; end
      end
      step(r, e);
    end
    clear_pend();
    for (int c = 0; c < 12; c++) step(1'b0, 1'b1);
    chk("rand_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
